// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE-column pass scheduler and PE control.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pe_ctrl_pkg;

  // Width of each config dimension field (oc, ic, fw), each 1..31.
  localparam int CFG_W       = 5;
  // Idle cycles after a compute phase before the next load or done.
  localparam int DRAIN_CYC   = 2;
  // Cycles a PE spends per MAC; also used by the PE-side control.
  localparam int CYC_PER_MAC = 4;
  // 31*31*31 = 29791 fits in 15 bits.
  localparam int LOAD_LEN_W  = 15;
  // 4*29791 + slack fits in 17 bits.
  localparam int RUN_MAX_W   = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } pe_state_e;

  // Words streamed per pass: one per filter tap per channel pair.
  function automatic logic [LOAD_LEN_W-1:0] macs_per_pass(
    input logic [CFG_W-1:0] oc,
    input logic [CFG_W-1:0] ic,
    input logic [CFG_W-1:0] fw
  );
    logic [LOAD_LEN_W-1:0] prod;
    prod = LOAD_LEN_W'(fw) * LOAD_LEN_W'(oc) * LOAD_LEN_W'(ic);
    return prod;
  endfunction

endpackage

// File: rtl/pe_cfg_calc.sv
// Derives per-pass load length, watchdog limit and a config-valid flag.
// Latency: purely combinational; the caller latches the results on accept.
// Backpressure: none.
//
// Ports:
//   oc, ic, fw   config dimensions (each must be non-zero)
//   passes       number of passes (must be non-zero)
//   load_len     fw*oc*ic, cycles of load per pass
//   run_max      CYC_PER_MAC*load_len + SLACK, compute-phase watchdog limit
//   cfg_bad      any field is zero
module pe_cfg_calc
  import pe_ctrl_pkg::*;
#(
  parameter int PASS_W = 8,
  parameter int SLACK  = 16
) (
  input  logic [CFG_W-1:0]      oc,
  input  logic [CFG_W-1:0]      ic,
  input  logic [CFG_W-1:0]      fw,
  input  logic [PASS_W-1:0]     passes,
  output logic [LOAD_LEN_W-1:0] load_len,
  output logic [RUN_MAX_W-1:0]  run_max,
  output logic                  cfg_bad
);

  always_comb begin
    load_len = macs_per_pass(oc, ic, fw);
    // Widen before scaling so the x4 never truncates.
    run_max  = RUN_MAX_W'(CYC_PER_MAC) * RUN_MAX_W'(load_len) + RUN_MAX_W'(SLACK);
    cfg_bad  = (oc == '0) || (ic == '0) || (fw == '0) || (passes == '0);
  end

endmodule

// File: rtl/pe_pass_sched.sv
// Sequences a PE column through load / gap / run / drain for each of N passes.
// Latency: first load cycle one cycle after config accept; all outputs registered.
// Backpressure: cfg_ready low whenever not idle; config offered while busy is ignored.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   cfg_valid/cfg_ready      config handshake; cfg_oc/ic/fw/passes latched on accept
//   abort                    return to idle from any busy state, no done/err
//   pe_complete[NUM_PE]      per-PE completion pulses, only observed while running
//   load, gb_rd_en, start    broadcast PE controls and buffer read strobe
//   pass_idx                 current pass, 0-based
//   busy, done, err          status; done/err are single-cycle pulses
module pe_pass_sched
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE = 3,
  parameter int PASS_W = 8,
  parameter int SLACK  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CFG_W-1:0]  cfg_oc,
  input  logic [CFG_W-1:0]  cfg_ic,
  input  logic [CFG_W-1:0]  cfg_fw,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              abort,
  input  logic [NUM_PE-1:0] pe_complete,
  output logic              load,
  output logic              start,
  output logic              gb_rd_en,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  pe_state_e state, state_nxt;

  // One counter serves as load-cycle, run-watchdog and drain counter.
  logic [RUN_MAX_W-1:0]  cnt, cnt_nxt;
  logic [NUM_PE-1:0]     cap, cap_nxt;
  logic [PASS_W-1:0]     pass_q, pass_nxt;
  logic                  err_nxt;
  logic                  cfg_take;
  logic                  all_done;

  logic [LOAD_LEN_W-1:0] load_len_q;
  logic [RUN_MAX_W-1:0]  run_max_q;
  logic [PASS_W-1:0]     passes_q;

  logic [LOAD_LEN_W-1:0] calc_load_len;
  logic [RUN_MAX_W-1:0]  calc_run_max;
  logic                  calc_bad;

  logic load_q, start_q, busy_q, done_q, err_q, ready_q;

  // Derived values come from the incoming fields and are latched on accept,
  // so LOAD can start on the very next cycle with its length already known.
  pe_cfg_calc #(
    .PASS_W (PASS_W),
    .SLACK  (SLACK)
  ) u_cfg_calc (
    .oc       (cfg_oc),
    .ic       (cfg_ic),
    .fw       (cfg_fw),
    .passes   (cfg_passes),
    .load_len (calc_load_len),
    .run_max  (calc_run_max),
    .cfg_bad  (calc_bad)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap;
    pass_nxt  = pass_q;
    err_nxt   = 1'b0;
    cfg_take  = 1'b0;
    // Include this cycle's pulses so a PE finishing on the exit cycle counts.
    all_done  = &(cap | pe_complete);

    unique case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (calc_bad) begin
            err_nxt = 1'b1;
          end else begin
            cfg_take  = 1'b1;
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
            pass_nxt  = '0;
          end
        end
      end

      ST_LOAD: begin
        if (cnt == RUN_MAX_W'(load_len_q) - RUN_MAX_W'(1)) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + RUN_MAX_W'(1);
        end
      end

      ST_GAP: begin
        cap_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        cap_nxt = cap | pe_complete;
        // Completion on the watchdog's last cycle still counts as success.
        if (all_done) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else if (cnt == run_max_q - RUN_MAX_W'(1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          cap_nxt   = '0;
          pass_nxt  = '0;
        end else begin
          cnt_nxt = cnt + RUN_MAX_W'(1);
        end
      end

      ST_DRAIN: begin
        if (cnt == RUN_MAX_W'(DRAIN_CYC - 1)) begin
          cnt_nxt = '0;
          if (pass_q == passes_q - PASS_W'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            pass_nxt  = pass_q + PASS_W'(1);
            state_nxt = ST_LOAD;
          end
        end else begin
          cnt_nxt = cnt + RUN_MAX_W'(1);
        end
      end

      ST_DONE: begin
        pass_nxt  = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        cap_nxt   = '0;
        pass_nxt  = '0;
      end
    endcase

    // Abort overrides completion and watchdog outcomes in the same cycle.
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      cap_nxt   = '0;
      pass_nxt  = '0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cap   <= '0;
      pass_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cap   <= cap_nxt;
      pass_q <= pass_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_len_q <= '0;
      run_max_q  <= '0;
      passes_q   <= '0;
    end else if (cfg_take) begin
      load_len_q <= calc_load_len;
      run_max_q  <= calc_run_max;
      passes_q   <= cfg_passes;
    end
  end

  // Outputs are decoded from the next state into flops so PEs see clean,
  // glitch-free broadcasts with no input-to-output combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      load_q  <= (state_nxt == ST_LOAD);
      start_q <= (state_nxt == ST_RUN);
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_DONE);
      err_q   <= err_nxt;
      ready_q <= (state_nxt == ST_IDLE);
    end
  end

  assign load      = load_q;
  assign gb_rd_en  = load_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cfg_ready = ready_q;
  assign pass_idx  = pass_q;

endmodule

// File: tb/tb_pe_pass_sched.sv
// Testbench for pe_pass_sched: per-cycle output trace against a phase-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_pass_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_oc, cfg_ic, cfg_fw;
  logic [7:0] cfg_passes;
  logic       abort;
  logic [2:0] pe_complete;
  logic       load, start, gb_rd_en, busy, done, err;
  logic [7:0] pass_idx;

  int checks   = 0;
  int failures = 0;

  pe_pass_sched #(.NUM_PE(3), .PASS_W(8), .SLACK(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_oc      (cfg_oc),
    .cfg_ic      (cfg_ic),
    .cfg_fw      (cfg_fw),
    .cfg_passes  (cfg_passes),
    .abort       (abort),
    .pe_complete (pe_complete),
    .load        (load),
    .start       (start),
    .gb_rd_en    (gb_rd_en),
    .pass_idx    (pass_idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       gb;
    logic       bz;
    logic       dn;
    logic       er;
    logic       rdy;
    logic [7:0] pidx;
  } obs_t;

  obs_t exp_q[$];
  obs_t got_q[$];

  function automatic obs_t mk(input logic ld, input logic st, input logic bz,
                              input logic dn, input logic er, input int p);
    obs_t o;
    o.ld = ld; o.st = st; o.gb = ld; o.bz = bz; o.dn = dn; o.er = er;
    o.rdy = ~bz; o.pidx = 8'(p);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ld = load; o.st = start; o.gb = gb_rd_en; o.bz = busy; o.dn = done;
    o.er = err; o.rdy = cfg_ready; o.pidx = pass_idx;
    return o;
  endfunction

  // Phase-level model: each pass is L load cycles, one gap, a run phase that
  // lasts until the last PE's completion (or the watchdog limit), two drain
  // cycles; the final pass is followed by a single done cycle.
  function automatic void build_exp(input int oc, input int ic, input int fw, input int passes,
                                    input int c0, input int c1, input int c2, input int abort_at);
    int  L, rm, mx, rl;
    bit  tout;
    exp_q.delete();
    if (oc == 0 || ic == 0 || fw == 0 || passes == 0) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
    end else begin
      L  = oc * ic * fw;
      rm = 4 * L + 16;
      mx = c0;
      if (c1 > mx) mx = c1;
      if (c2 > mx) mx = c2;
      tout = (c0 < 0) || (c1 < 0) || (c2 < 0) || (mx > rm - 1);
      rl = tout ? rm : mx + 1;
      for (int p = 0; p < passes; p++) begin
        repeat (L) exp_q.push_back(mk(1, 0, 1, 0, 0, p));
        exp_q.push_back(mk(0, 0, 1, 0, 0, p));
        repeat (rl) exp_q.push_back(mk(0, 1, 1, 0, 0, p));
        if (tout) begin
          exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
          break;
        end
        repeat (2) exp_q.push_back(mk(0, 0, 1, 0, 0, p));
        if (p == passes - 1) exp_q.push_back(mk(0, 0, 1, 1, 0, p));
      end
    end
    if (abort_at >= 0)
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
  endfunction

  // Offers one config at the next rising edge and records exp_q.size() cycles
  // of outputs. PEs react to start: PE p pulses on run cycle c_p (-1 = never).
  task automatic run_txn(input int oc, input int ic, input int fw, input int passes,
                         input int c0, input int c1, input int c2, input int abort_at,
                         input int hold, input bit noise);
    int run_cnt = 0;
    int cp[3];
    cp[0] = c0; cp[1] = c1; cp[2] = c2;
    got_q.delete();
    cfg_oc = 5'(oc); cfg_ic = 5'(ic); cfg_fw = 5'(fw); cfg_passes = 8'(passes);
    cfg_valid = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got_q.push_back(sample());
      cfg_valid   = (i < hold);
      abort       = (i == abort_at);
      pe_complete = '0;
      if (start) begin
        for (int p = 0; p < 3; p++)
          if (cp[p] == run_cnt || (noise && cp[p] >= 0 && run_cnt > cp[p] && $urandom_range(0, 1) == 1))
            pe_complete[p] = 1'b1;
        run_cnt++;
      end else begin
        run_cnt = 0;
        if (noise) pe_complete = 3'($urandom);
      end
    end
    cfg_valid = 1'b0; abort = 1'b0; pe_complete = '0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0; cfg_valid = 1'b0; abort = 1'b0; pe_complete = '0;
    cfg_oc = '0; cfg_ic = '0; cfg_fw = '0; cfg_passes = '0;
    #2 rst = 1'b1;
    #2 o = sample();
    checks++;
    if (o !== mk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_assert got=%b exp=%b", o, mk(0, 0, 0, 0, 0, 0));
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = sample();
    checks++;
    if (o !== mk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", o, mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_single_pass();
    int nload = 0;
    build_exp(2, 1, 3, 1, 23, 23, 23, -1);
    run_txn(2, 1, 3, 1, 23, 23, 23, -1, 2, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_pass cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].ld) nload++;
    end
    checks++;
    if (nload != 6) begin
      failures++;
      $display("FAIL single_pass_load_len got=%0d exp=6", nload);
    end
  endtask

  task automatic test_multi_pass();
    int ndone = 0;
    build_exp(2, 1, 3, 3, 9, 14, 19, -1);
    run_txn(2, 1, 3, 3, 9, 14, 19, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL multi_pass cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].dn) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL multi_pass_done_count got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_bad_cfg();
    build_exp(2, 0, 3, 1, 0, 0, 0, -1);
    run_txn(2, 0, 3, 1, 0, 0, 0, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bad_cfg cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    build_exp(1, 1, 1, 1, -1, -1, -1, -1);
    run_txn(1, 1, 1, 1, -1, -1, -1, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL watchdog cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    // Abort on load cycle 3.
    build_exp(2, 1, 3, 1, 5, 9, 12, 3);
    run_txn(2, 1, 3, 1, 5, 9, 12, 3, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_load cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
    end
    // Abort together with the final completion: 6 load + 1 gap + run cycle 12.
    build_exp(2, 1, 3, 1, 5, 9, 12, 19);
    run_txn(2, 1, 3, 1, 5, 9, 12, 19, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_complete cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit   found = 1'b0;
    obs_t o;
    cfg_oc = 5'd1; cfg_ic = 5'd2; cfg_fw = 5'd2; cfg_passes = 8'd3;
    cfg_valid = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      cfg_valid   = 1'b0;
      pe_complete = {3{start}};
      if (start && pass_idx == 8'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL async_reset_reach_run got=timeout exp=run_in_pass1");
    end
    pe_complete = '0;
    #2 rst = 1'b1;
    #1 o = sample();
    checks++;
    if (o !== mk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=%b", o, mk(0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build_exp(2, 2, 1, 2, 3, 1, 2, -1);
    run_txn(2, 2, 1, 2, 3, 1, 2, -1, 0, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL async_reset_rerun cyc=%0d got=%b exp=%b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int oc, ic, fw, ps, rm, ab, hold;
    int c[3];
    for (int it = 0; it < 8; it++) begin
      oc = $urandom_range(1, 4); ic = $urandom_range(1, 4); fw = $urandom_range(1, 4);
      ps = $urandom_range(1, 3);
      rm = 4 * oc * ic * fw + 16;
      for (int p = 0; p < 3; p++)
        c[p] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, rm + 2);
      hold = $urandom_range(0, 2);
      build_exp(oc, ic, fw, ps, c[0], c[1], c[2], -1);
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(3, exp_q.size() - 5);
      build_exp(oc, ic, fw, ps, c[0], c[1], c[2], ab);
      run_txn(oc, ic, fw, ps, c[0], c[1], c[2], ab, hold, 1'b1);
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random it=%0d cfg=%0d/%0d/%0d/%0d cyc=%0d got=%b exp=%b",
                   it, oc, ic, fw, ps, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_bad_cfg();
    test_watchdog();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
